// File: rtl/noc_vc_port_if.sv
// ---------------------------------------------------------------------------
// noc_vc_port_if
// Link-side bundle of the virtual-channel router port. The upstream half
// carries flits in (valid_i, vc_i, data_i) and credits back out (credit_o).
// The downstream half carries flits out (enable_o, vc_o, data_o) and credits
// back in (credit_i).
//
// Parameters:
//   DATA_W - flit width in bits
//   VC_NUM - number of virtual channels (>= 1)
//
// Modports:
//   slave  - the router port itself (consumes flits/credits, produces them)
//   master - the link/switch environment that drives the port
//
// DATA_W and VC_NUM must match the values given to noc_vc_port.
// ---------------------------------------------------------------------------
interface noc_vc_port_if #(
  parameter int DATA_W = 16,
  parameter int VC_NUM = 2
);
  localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  logic              valid_i;
  logic [VC_W-1:0]   vc_i;
  logic [DATA_W-1:0] data_i;
  logic [VC_NUM-1:0] credit_i;

  logic              enable_o;
  logic [VC_W-1:0]   vc_o;
  logic [DATA_W-1:0] data_o;
  logic [VC_NUM-1:0] credit_o;

  modport slave (
    input  valid_i, vc_i, data_i, credit_i,
    output enable_o, vc_o, data_o, credit_o
  );

  modport master (
    output valid_i, vc_i, data_i, credit_i,
    input  enable_o, vc_o, data_o, credit_o
  );
endinterface

// File: rtl/noc_vc_port.sv
// ---------------------------------------------------------------------------
// noc_vc_port
// Virtual-channel router port. Flits arriving from the upstream link are
// buffered in one FIFO per VC. Each cycle a round-robin arbiter picks one VC
// that has a buffered flit and at least one downstream credit, pops its head
// flit and presents it on the registered downstream outputs together with a
// one-cycle credit pulse back upstream for the freed slot.
//
// Parameters:
//   DATA_W - flit width
//   VC_NUM - number of virtual channels (>= 1)
//   DEPTH  - per-VC FIFO depth and initial downstream credit count per VC
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   rst        - synchronous active-high reset
//   bus        - link bundle (noc_vc_port_if.slave):
//                  valid_i/vc_i/data_i   incoming flit
//                  credit_i              per-VC credit return from downstream
//                  enable_o/vc_o/data_o  outgoing flit (registered)
//                  credit_o              per-VC freed-slot pulse to upstream
//   ovf_err_o  - sticky: a flit arrived on a full VC FIFO and was dropped
//   cred_err_o - sticky: a credit arrived on a VC already holding DEPTH
// ---------------------------------------------------------------------------
module noc_vc_port #(
  parameter int DATA_W = 16,
  parameter int VC_NUM = 2,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  noc_vc_port_if.slave     bus,
  output logic             ovf_err_o,
  output logic             cred_err_o
);

  localparam int VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem    [VC_NUM][DEPTH];
  logic [PTR_W-1:0]  rd_ptr [VC_NUM];
  logic [PTR_W-1:0]  wr_ptr [VC_NUM];
  logic [CNT_W-1:0]  count  [VC_NUM];
  logic [CNT_W-1:0]  cred   [VC_NUM];
  logic [VC_W-1:0]   last_grant;

  logic [VC_NUM-1:0] eligible;
  logic [VC_NUM-1:0] sent;
  logic [VC_NUM-1:0] push;
  logic              grant_valid;
  logic [VC_W-1:0]   grant_vc;
  logic [VC_W-1:0]   cand;
  logic [DATA_W-1:0] head;
  logic              ovf_hit;
  logic              cred_hit;

  // Pointers wrap explicitly so DEPTH does not have to be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // A VC can send only if it has a buffered flit and a downstream credit.
  // Both come from registered state, so this cycle's pushes and credit
  // returns only become visible to the arbiter one cycle later.
  always_comb begin
    eligible = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      eligible[v] = (count[v] != '0) && (cred[v] != '0);
    end
  end

  // Round-robin search starting one past the previous winner; the first
  // eligible VC found wins and is popped this cycle.
  always_comb begin
    grant_valid = 1'b0;
    grant_vc    = '0;
    cand        = '0;
    sent        = '0;
    for (int i = 1; i <= VC_NUM; i++) begin
      cand = VC_W'((int'(last_grant) + i) % VC_NUM);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_vc    = cand;
      end
    end
    if (grant_valid) begin
      sent[grant_vc] = 1'b1;
    end
  end

  assign head = mem[grant_vc][rd_ptr[grant_vc]];

  // A full FIFO still accepts a write when its head is popped in the same
  // cycle, so back-to-back traffic on a full VC loses nothing. Any other
  // write to a full FIFO is dropped and flagged. Credits returned to a VC
  // that already holds DEPTH credits are flagged unless a send on that VC
  // absorbs them.
  always_comb begin
    push     = '0;
    ovf_hit  = 1'b0;
    cred_hit = 1'b0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (bus.valid_i && (bus.vc_i == VC_W'(v))) begin
        if ((count[v] != CNT_FULL) || sent[v]) begin
          push[v] = 1'b1;
        end else begin
          ovf_hit = 1'b1;
        end
      end
      if (bus.credit_i[v] && !sent[v] && (cred[v] == CNT_FULL)) begin
        cred_hit = 1'b1;
      end
    end
  end

  // Flit storage carries no reset: a slot is only read after it was written,
  // because the occupancy count gates eligibility.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (push[v]) begin
        mem[v][wr_ptr[v]] <= bus.data_i;
      end
    end
  end

  // Per-VC FIFO bookkeeping and downstream credit counters. Reset drops
  // every buffered flit and restores the full credit allowance.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (rst) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        count[v]  <= '0;
        cred[v]   <= CNT_FULL;
      end else begin
        if (push[v]) begin
          wr_ptr[v] <= ptr_inc(wr_ptr[v]);
        end
        if (sent[v]) begin
          rd_ptr[v] <= ptr_inc(rd_ptr[v]);
        end
        count[v] <= count[v] + CNT_W'(push[v]) - CNT_W'(sent[v]);
        if (bus.credit_i[v] && !sent[v]) begin
          if (cred[v] != CNT_FULL) begin
            cred[v] <= cred[v] + CNT_ONE;
          end
        end else if (!bus.credit_i[v] && sent[v]) begin
          cred[v] <= cred[v] - CNT_ONE;
        end
      end
    end
  end

  // Registered downstream outputs. vc_o/data_o keep the last flit when
  // nothing is sent; credit_o mirrors the popped VC for one cycle.
  // last_grant resets to the highest VC so VC0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.enable_o <= 1'b0;
      bus.vc_o     <= '0;
      bus.data_o   <= '0;
      bus.credit_o <= '0;
      last_grant   <= VC_W'(VC_NUM - 1);
    end else begin
      bus.enable_o <= grant_valid;
      bus.credit_o <= sent;
      if (grant_valid) begin
        bus.vc_o   <= grant_vc;
        bus.data_o <= head;
        last_grant <= grant_vc;
      end
    end
  end

  // Error flags are sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err_o  <= 1'b0;
      cred_err_o <= 1'b0;
    end else begin
      if (ovf_hit) begin
        ovf_err_o <= 1'b1;
      end
      if (cred_hit) begin
        cred_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_vc_port.sv
// ---------------------------------------------------------------------------
// tb_noc_vc_port
// Self-checking bench for noc_vc_port with DATA_W=16, VC_NUM=2, DEPTH=4.
// Each stimulus step drives one cycle of inputs, waits for the rising edge,
// then samples the outputs 1 time unit later, i.e. the outputs of the next
// cycle. A vector table covers single-flit latency, credit exhaustion and
// round-robin interleave; hand-written sequences cover FIFO overflow with
// contended credit release, credit overflow and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_noc_vc_port;

  localparam int DATA_W = 16;
  localparam int VC_NUM = 2;
  localparam int DEPTH  = 4;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        vc;
    logic [15:0] data;
    logic [1:0]  credit;
    logic        en;
    logic        vco;
    logic [15:0] datao;
    logic [1:0]  credo;
    logic        ovf;
    logic        cerr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic ovf_err;
  logic cred_err;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  noc_vc_port_if #(.DATA_W(DATA_W), .VC_NUM(VC_NUM)) bus ();

  noc_vc_port #(.DATA_W(DATA_W), .VC_NUM(VC_NUM), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ovf_err_o  (ovf_err),
    .cred_err_o (cred_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then move to just after the closing edge.
  task automatic apply_stimulus(input logic r, input logic v, input logic c,
                                input logic [15:0] d, input logic [1:0] cr);
    rst          = r;
    bus.valid_i  = v;
    bus.vc_i     = c;
    bus.data_i   = d;
    bus.credit_i = cr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic en, input logic vco,
                           input logic [15:0] datao, input logic [1:0] credo,
                           input logic ovf, input logic cerr);
    check_output({tag, ".enable_o"},   32'(bus.enable_o), 32'(en));
    check_output({tag, ".vc_o"},       32'(bus.vc_o),     32'(vco));
    check_output({tag, ".data_o"},     32'(bus.data_o),   32'(datao));
    check_output({tag, ".credit_o"},   32'(bus.credit_o), 32'(credo));
    check_output({tag, ".ovf_err_o"},  32'(ovf_err),      32'(ovf));
    check_output({tag, ".cred_err_o"}, 32'(cred_err),     32'(cerr));
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic c,
                              input logic [15:0] d, input logic [1:0] cr,
                              input logic e, input logic vo, input logic [15:0] dout,
                              input logic [1:0] co, input logic ov, input logic ce);
    vec_t t;
    t.rst = r;   t.valid = v;  t.vc = c;      t.data = d;   t.credit = cr;
    t.en = e;    t.vco = vo;   t.datao = dout; t.credo = co; t.ovf = ov; t.cerr = ce;
    return t;
  endfunction

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b0;
    bus.valid_i  = 1'b0;
    bus.vc_i     = 1'b0;
    bus.data_i   = '0;
    bus.credit_i = '0;

    // Expected outputs are those of the cycle after the row's inputs.
    //          rst vld vc data      cred  en vc dout      co    ovf cerr
    // Single flit
    vecs.push_back(mk(1, 0, 0, 16'h0000, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'hA5A5, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 2'b00, 1, 0, 16'hA5A5, 2'b01, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 2'b00, 0, 0, 16'hA5A5, 2'b00, 0, 0));
    // Credit exhaustion on VC1, release in cycle 10
    vecs.push_back(mk(1, 0, 0, 16'h0000, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0001, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0002, 2'b00, 1, 1, 16'h0001, 2'b10, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0003, 2'b00, 1, 1, 16'h0002, 2'b10, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0004, 2'b00, 1, 1, 16'h0003, 2'b10, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0005, 2'b00, 1, 1, 16'h0004, 2'b10, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 2'b00, 0, 1, 16'h0004, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 2'b00, 0, 1, 16'h0004, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 2'b00, 0, 1, 16'h0004, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 2'b00, 0, 1, 16'h0004, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 2'b10, 0, 1, 16'h0004, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 2'b00, 1, 1, 16'h0005, 2'b10, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 2'b00, 0, 1, 16'h0005, 2'b00, 0, 0));
    // Round-robin interleave
    vecs.push_back(mk(1, 0, 0, 16'h0000, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h1000, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h2000, 2'b00, 1, 0, 16'h1000, 2'b01, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h1001, 2'b00, 1, 1, 16'h2000, 2'b10, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h2001, 2'b00, 1, 0, 16'h1001, 2'b01, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h1002, 2'b00, 1, 1, 16'h2001, 2'b10, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h2002, 2'b00, 1, 0, 16'h1002, 2'b01, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 2'b00, 1, 1, 16'h2002, 2'b10, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 2'b00, 0, 1, 16'h2002, 2'b00, 0, 0));

    $display("[TB] running %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].valid, vecs[i].vc, vecs[i].data, vecs[i].credit);
      check_all($sformatf("row%0d", i), vecs[i].en, vecs[i].vco, vecs[i].datao,
                vecs[i].credo, vecs[i].ovf, vecs[i].cerr);
    end

    // Overflow: exhaust both VCs' credits, overfill VC0, park two flits on
    // VC1, then release credits on both VCs at once.
    $display("[TB] overflow sequence");
    apply_stimulus(1, 0, 0, 16'h0000, 2'b00);
    check_all("ovf.reset", 0, 0, 16'h0000, 2'b00, 0, 0);
    for (int k = 0; k < 4; k++) apply_stimulus(0, 1, 1, 16'(16'h3001 + k), 2'b00);
    for (int k = 0; k < 4; k++) apply_stimulus(0, 1, 0, 16'(16'h4001 + k), 2'b00);
    apply_stimulus(0, 1, 0, 16'h5001, 2'b00);
    check_all("ovf.last_vc0_credit", 1, 0, 16'h4004, 2'b01, 0, 0);
    for (int k = 1; k < 4; k++) apply_stimulus(0, 1, 0, 16'(16'h5001 + k), 2'b00);
    check_all("ovf.fifo_full", 0, 0, 16'h4004, 2'b00, 0, 0);
    apply_stimulus(0, 1, 0, 16'h5005, 2'b00);
    check_all("ovf.dropped", 0, 0, 16'h4004, 2'b00, 1, 0);
    apply_stimulus(0, 1, 1, 16'h6001, 2'b00);
    check_all("ovf.park1", 0, 0, 16'h4004, 2'b00, 1, 0);
    apply_stimulus(0, 1, 1, 16'h6002, 2'b00);
    check_all("ovf.park2", 0, 0, 16'h4004, 2'b00, 1, 0);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b11);
    check_all("ovf.credit_wait", 0, 0, 16'h4004, 2'b00, 1, 0);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b11);
    check_all("ovf.rr1", 1, 1, 16'h6001, 2'b10, 1, 0);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b00);
    check_all("ovf.rr2", 1, 0, 16'h5001, 2'b01, 1, 0);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b00);
    check_all("ovf.rr3", 1, 1, 16'h6002, 2'b10, 1, 0);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b00);
    check_all("ovf.rr4", 1, 0, 16'h5002, 2'b01, 1, 0);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b00);
    check_all("ovf.stall", 0, 0, 16'h5002, 2'b00, 1, 0);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b01);
    check_all("ovf.credit_vc0", 0, 0, 16'h5002, 2'b00, 1, 0);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b01);
    check_all("ovf.drain3", 1, 0, 16'h5003, 2'b01, 1, 0);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b00);
    check_all("ovf.drain4", 1, 0, 16'h5004, 2'b01, 1, 0);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b00);
    check_all("ovf.no_fifth", 0, 0, 16'h5004, 2'b00, 1, 0);

    // Credit overflow on an idle port, then a normal send.
    $display("[TB] credit overflow sequence");
    apply_stimulus(1, 0, 0, 16'h0000, 2'b00);
    check_all("cerr.reset", 0, 0, 16'h0000, 2'b00, 0, 0);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b01);
    check_all("cerr.flag", 0, 0, 16'h0000, 2'b00, 0, 1);
    apply_stimulus(0, 1, 0, 16'hBEEF, 2'b00);
    check_all("cerr.push", 0, 0, 16'h0000, 2'b00, 0, 1);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b00);
    check_all("cerr.send", 1, 0, 16'hBEEF, 2'b01, 0, 1);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b00);
    check_all("cerr.idle", 0, 0, 16'hBEEF, 2'b00, 0, 1);

    // Reset with three flits stalled on VC0; inputs during reset are ignored.
    $display("[TB] reset mid-operation sequence");
    apply_stimulus(1, 0, 0, 16'h0000, 2'b00);
    for (int k = 0; k < 7; k++) apply_stimulus(0, 1, 0, 16'(16'h8001 + k), 2'b00);
    check_all("rstmid.stalled", 0, 0, 16'h8004, 2'b00, 0, 0);
    apply_stimulus(1, 1, 0, 16'hDEAD, 2'b01);
    check_all("rstmid.reset", 0, 0, 16'h0000, 2'b00, 0, 0);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b00);
    check_all("rstmid.flushed", 0, 0, 16'h0000, 2'b00, 0, 0);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(0, 1, 0, 16'(16'h7001 + k), 2'b00);
      if (k == 0) check_all("rstmid.lat", 0, 0, 16'h0000, 2'b00, 0, 0);
      else        check_all($sformatf("rstmid.send%0d", k), 1, 0, 16'(16'h7000 + k), 2'b01, 0, 0);
    end
    apply_stimulus(0, 0, 0, 16'h0000, 2'b00);
    check_all("rstmid.send4", 1, 0, 16'h7004, 2'b01, 0, 0);
    apply_stimulus(0, 0, 0, 16'h0000, 2'b00);
    check_all("rstmid.idle", 0, 0, 16'h7004, 2'b00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_vc_port.md
# noc_vc_port

Parametrised virtual-channel router port: accepts flits from an upstream link under credit flow control, buffers them in per-VC FIFOs, and forwards them one per cycle to the downstream link. It tracks downstream credits per VC and arbitrates round-robin among eligible VCs. It generalises the single-channel, 16-bit router port to configurable width, depth and VC count, and adds error detection. It sits between a link and the switch stage of each NoC router.

## Interface
- DATA_W, 16, flit width in bits
- VC_NUM, 2, number of virtual channels (≥1)
- DEPTH, 4, per-VC input FIFO depth; also initial downstream credit count per VC
- VC_W, $clog2(VC_NUM) (min 1), derived VC index width; not overridden
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  upstream flit valid
- vc_i  in  VC_W  VC of incoming flit
- data_i  in  DATA_W  incoming flit
- credit_i  in  VC_NUM  per-VC credit return from downstream, one cycle pulse per credit
- enable_o  out  1  downstream flit valid
- vc_o  out  VC_W  VC of outgoing flit
- data_o  out  DATA_W  outgoing flit
- credit_o  out  VC_NUM  per-VC credit pulse to upstream, one bit per freed slot
- ovf_err_o  out  1  sticky: flit arrived on a full VC FIFO
- cred_err_o  out  1  sticky: credit received on a VC already at DEPTH credits

## Operation
- Write: valid_i high at an edge pushes data_i into FIFO[vc_i]. If FIFO[vc_i] is full and not being popped that cycle, the flit is dropped and ovf_err_o sets.
- Eligibility: VC v is eligible when FIFO[v] is non-empty and cred[v] > 0. Occupancy and credits are registered state; same-cycle writes and credits are not visible until the next cycle.
- Arbitration: round-robin. Search starts at last_grant+1 mod VC_NUM. The first eligible VC wins, and last_grant updates to the winner. last_grant resets to VC_NUM-1, so VC0 has first priority.
- Send: the winner's head flit is popped. At the next edge, enable_o=1, vc_o=winner, data_o=flit, and credit_o has the winner bit set for one cycle. cred[winner] decrements.
- No winner: enable_o=0 and credit_o=0. vc_o and data_o hold their last values.
- Credit update per VC: cred += credit_i[v] − sent[v]. Simultaneous credit and send on the same VC leaves cred unchanged. If credit_i[v] arrives with cred[v]==DEPTH and no send on v, cred stays at DEPTH and cred_err_o sets.
- Throughput: at most one flit per cycle across all VCs. Pop and push on the same full FIFO in the same cycle is legal and no flit is dropped.
- FIFO pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- Error flags clear only on rst.

## Timing
- Reset, applied at any edge: enable_o=0, vc_o=0, data_o=0, credit_o=0, ovf_err_o=0, cred_err_o=0.
- Reset also empties all FIFOs, sets cred[v]=DEPTH and last_grant=VC_NUM-1.
- Reset mid-operation discards buffered flits. No credit_o is issued for discarded flits, and inputs in the reset cycle are ignored.
- Latency: valid_i in cycle k gives enable_o in cycle k+2 at the earliest, with credit_o for that VC in the same cycle k+2.
- Credit-to-send: credit_i in cycle c unblocks a stalled VC. Its flit appears in cycle c+2 at the earliest.
- Error flags assert in the cycle after the offending edge.

## Test plan
Parameters for all tests: DATA_W=16, VC_NUM=2, DEPTH=4.
- **Single flit:** after rst, valid_i=1, vc_i=0, data_i=16'hA5A5 in cycle 1.
  -> Cycle 3: enable_o=1, vc_o=0, data_o=16'hA5A5, credit_o=2'b01. Cycle 4: enable_o=0, data_o still 16'hA5A5.
- **Credit exhaustion:** no credit_i; send 5 flits 16'h0001..0005 on VC1 in cycles 1-5.
  -> Flits 1-4 are emitted in cycles 3-6. Flit 5 is held and enable_o=0 from cycle 7.
  -> credit_i=2'b10 in cycle 10 gives data_o=16'h0005 in cycle 12. ovf_err_o stays 0.
- **Round-robin:** preload VC0 with 16'h1000..1002 and VC1 with 16'h2000..2002 in the same cycles.
  -> Output order is 1000, 2000, 1001, 2001, 1002, 2002, one per cycle with no gaps.
- **Overflow:** send 4 flits to VC1 to exhaust credits, then 5 flits to VC0 while VC0's credits are otherwise consumed so VC0 cannot drain.
  -> The 5th VC0 flit is dropped and ovf_err_o=1 the next cycle.
  -> Once credit flows again, only 4 VC0 flits emerge. ovf_err_o remains 1 until rst.
- **Credit overflow:** idle port, credit_i=2'b01 -> cred_err_o=1 next cycle. A subsequent send still behaves normally.
- **Reset mid-operation:** with 3 flits buffered on VC0, assert rst for one cycle.
  -> Outputs go to their reset values next cycle with no credit_o pulses.
  -> A new flit sent afterwards emerges with 2-cycle latency, and 4 sends succeed without credit_i.
